scan_chain_controller: RTL
==========================

// Module: scan_chain_controller
// PURPOSE
//  Tester-side driver for a single mux-D scan chain such as the FSM state-register chain.
//  Per request it loads a CHAIN_LEN-bit pattern through scan_in with scan_en=1.
//  It then drops scan_en for CAP_CYCLES functional capture clocks and unloads the
//  captured chain contents from scan_out. Sits between a test sequencer and the chain under test.
// PARAMETERS
//  CHAIN_LEN   2  number of scan flops in the chain (>=1)
//  CAP_CYCLES  1  functional clocks with scan_en=0 between load and unload (>=1)
// PORTS
//  clk           in   1          rising-edge clock, shared with the chain under test
//  rst           in   1          asynchronous, active-low reset
//  start         in   1          request; sampled only in IDLE
//  abort         in   1          synchronous cancel of a running sequence
//  pattern       in   CHAIN_LEN  load data; pattern[0] shifted first, ends in the last flop (nearest scan_out)
//  scan_out      in   1          serial output of the chain
//  scan_en       out  1          chain shift enable
//  scan_in       out  1          chain serial input
//  busy          out  1          high in every state except IDLE
//  done          out  1          one-cycle pulse; response valid in this cycle
//  response      out  CHAIN_LEN  unloaded data; response[k] = k-th bit observed on scan_out
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE. Outputs: scan_en=0, scan_in=0, busy=0, done=0, response=0.
//  - All outputs are registered. No combinational path from input to output.
//  - States:
//    - IDLE: start=1 & abort=0 latches pattern into the shift register and goes to LOAD.
//    - LOAD: CHAIN_LEN cycles. scan_en=1; scan_in=shreg[0]; shreg shifts right by 1 each edge.
//    - CAPTURE: CAP_CYCLES cycles. scan_en=0; scan_in=0.
//    - UNLOAD: CHAIN_LEN cycles. scan_en=1; scan_in=0 (fill). The edge ending unload
//      cycle k stores scan_out into response[k]. Unload cycle 0 sees the last flop's captured value.
//    - DONE: 1 cycle. done=1, busy=1, scan_en=0. Then returns to IDLE.
//  - Latency: done is high in the cycle following clock edge 2*CHAIN_LEN+CAP_CYCLES+1,
//    counting the edge that samples start as edge 1.
//  - response holds its value until the next sequence's first unload edge. It is not cleared at start.
//  - start while busy is ignored; no queuing.
//  - abort=1 in any non-IDLE state: IDLE on the next edge. scan_en=0, scan_in=0, no done pulse,
//    response keeps its bits as partially updated.
//  - start and abort both high in IDLE: abort wins, and the block stays in IDLE.
//  - The cycle counter is sized $clog2(max(CHAIN_LEN,CAP_CYCLES)+1). It reloads on every state
//    entry and never wraps within a state.
//  - rst asserted mid-sequence: immediate return to reset values. The chain contents are undefined afterwards.
// CONFIGURATION
//  SCAN_COMPARE_EN defined:
//    - Adds input ports expected[CHAIN_LEN-1:0] and mask[CHAIN_LEN-1:0], latched with pattern at start.
//    - Adds output port fail (1 bit). fail = |((response ^ expected) & mask) for the completed
//      unload. It is registered, updated in the DONE cycle, held until the next DONE, and reset to 0.
//  SCAN_COMPARE_EN undefined: expected, mask and fail ports and all compare logic are absent.
// TESTING (bench uses CHAIN_LEN=4, CAP_CYCLES=1, behavioural 4-flop chain whose
//   functional next-state is D=~Q)
//  1. Reset: rst=0 mid-LOAD -> scan_en=0, busy=0, done=0, response=0 with no clock edge;
//     after release, state is IDLE.
//  2. start with pattern=4'b1011 -> scan_in sequence 1,1,0,1 with scan_en=1 for 4 cycles,
//     then scan_en=0 for 1 cycle, then 4 unload cycles. done pulses at edge 10.
//     response=4'b0100 (inverted load).
//  3. start pulsed again while busy -> ignored. Exactly one done pulse and unchanged latency.
//  4. abort at unload cycle 2 -> IDLE next edge, scan_en=0, no done, busy=0;
//     a following start=1 is accepted normally.
//  5. start and abort both high in IDLE -> busy stays 0 and scan_en stays 0.
//  6. SCAN_COMPARE_EN: pattern=4'b1011, expected=4'b0100, mask=4'hF -> fail=0.
//     Then expected=4'b0101, mask=4'hF -> fail=1. Then same expected with mask=4'hE -> fail=0.

Source files
------------

// File: rtl/scan_chain_if.sv
// Sequencer-side request/response bundle for scan_chain_controller.
// Compare signals (expected, mask, fail) exist only when SCAN_COMPARE_EN is defined.
interface scan_chain_if #(
  parameter int unsigned CHAIN_LEN = 2
) ();

  logic                 start;
  logic                 abort;
  logic [CHAIN_LEN-1:0] pattern;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] response;
`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected;
  logic [CHAIN_LEN-1:0] mask;
  logic                 fail;
`endif

`ifdef SCAN_COMPARE_EN
  modport master (
    output start, abort, pattern, expected, mask,
    input  busy, done, response, fail
  );

  modport slave (
    input  start, abort, pattern, expected, mask,
    output busy, done, response, fail
  );
`else
  modport master (
    output start, abort, pattern,
    input  busy, done, response
  );

  modport slave (
    input  start, abort, pattern,
    output busy, done, response
  );
`endif

endinterface

// File: rtl/scan_chain_controller.sv
// Tester-side driver for one mux-D scan chain: load pattern, capture, unload response.
// SCAN_COMPARE_EN adds a masked compare of the unloaded response against an expected vector.
module scan_chain_controller #(
  parameter int unsigned CHAIN_LEN  = 2,
  parameter int unsigned CAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  scan_chain_if.slave seq,
  input  logic       scan_out,
  output logic       scan_en,
  output logic       scan_in
);

  localparam int unsigned MAX_CYC = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CNT_W-1:0]     unload_idx;
  logic [CHAIN_LEN-1:0] shreg, shreg_nxt;
  logic [CHAIN_LEN-1:0] response_q, response_nxt;
  logic                 scan_en_nxt, scan_in_nxt;
  logic                 busy_q, busy_nxt;
  logic                 done_q, done_nxt;
`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected_q, expected_nxt;
  logic [CHAIN_LEN-1:0] mask_q, mask_nxt;
  logic                 fail_q, fail_nxt;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      response_q <= '0;
      scan_en    <= 1'b0;
      scan_in    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCAN_COMPARE_EN
      expected_q <= '0;
      mask_q     <= '0;
      fail_q     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      response_q <= response_nxt;
      scan_en    <= scan_en_nxt;
      scan_in    <= scan_in_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
`ifdef SCAN_COMPARE_EN
      expected_q <= expected_nxt;
      mask_q     <= mask_nxt;
      fail_q     <= fail_nxt;
`endif
    end
  end

  // Next state, counter reload on entry, and next values of registered outputs
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    response_nxt = response_q;
    unload_idx   = CNT_W'(CHAIN_LEN - 1) - cnt;
`ifdef SCAN_COMPARE_EN
    expected_nxt = expected_q;
    mask_nxt     = mask_q;
`endif

    case (state)
      IDLE: begin
        if (seq.start && !seq.abort) begin
          state_nxt = LOAD;
          cnt_nxt   = CNT_W'(CHAIN_LEN - 1);
          shreg_nxt = seq.pattern;
`ifdef SCAN_COMPARE_EN
          expected_nxt = seq.expected;
          mask_nxt     = seq.mask;
`endif
        end
      end
      LOAD: begin
        if (seq.abort) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = CAPTURE;
          cnt_nxt   = CNT_W'(CAP_CYCLES - 1);
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
          shreg_nxt = shreg >> 1;
        end
      end
      CAPTURE: begin
        if (seq.abort) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = UNLOAD;
          cnt_nxt   = CNT_W'(CHAIN_LEN - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      UNLOAD: begin
        if (seq.abort) begin
          state_nxt = IDLE;
        end else begin
          // Bit k of the response is the k-th bit seen on scan_out
          for (int unsigned k = 0; k < CHAIN_LEN; k++) begin
            if (unload_idx == CNT_W'(k)) response_nxt[k] = scan_out;
          end
          if (cnt == '0) state_nxt = DONE;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    scan_en_nxt = (state_nxt == LOAD) || (state_nxt == UNLOAD);
    scan_in_nxt = (state_nxt == LOAD) && shreg_nxt[0];
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);
`ifdef SCAN_COMPARE_EN
    fail_nxt = fail_q;
    if (state_nxt == DONE) fail_nxt = |((response_nxt ^ expected_q) & mask_q);
`endif
  end

  assign seq.busy     = busy_q;
  assign seq.done     = done_q;
  assign seq.response = response_q;
`ifdef SCAN_COMPARE_EN
  assign seq.fail     = fail_q;
`endif

endmodule
